// File: rtl/bram_row_loader_pkg.sv
// simd_pkg: shared geometry, row type and loader states for the SIMD input path.
package simd_pkg;
   localparam int PE_COUNT   = 4;
   localparam int DATA_WIDTH = 32;
   localparam int BRAM_DEPTH = 2048;
   localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);
   typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} loader_state_e;
endpackage

// File: rtl/bram_row_loader_if.sv
// bram_row_loader_if: valid/ready row stream feeding the loader.
interface bram_row_loader_if;
   import simd_pkg::*;
   logic valid;
   logic ready;
   logic last;
   row_t data;
   modport master (output valid, data, last, input ready);
   modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/bram_row_loader.sv
// bram_row_loader: streams a frame of rows into the input BRAM, then holds in_data_valid
// until the processor reports completion.
module bram_row_loader
   import simd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [ADDR_WIDTH:0]   cfg_len,
   input  logic                  stall,
   bram_row_loader_if.slave      s,
   output logic [ADDR_WIDTH-1:0] BRAM_PORTA_0_addr,
   output row_t                  BRAM_PORTA_0_din,
   output logic                  BRAM_PORTA_0_we,
   output logic                  in_data_valid,
   input  logic                  out_data_valid,
   output logic                  busy,
   output logic                  err_len
);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(BRAM_DEPTH);
   loader_state_e state, state_n;
   logic [ADDR_WIDTH:0] cnt, len, len_clamp, sum;
   logic [ADDR_WIDTH-1:0] base, wr_addr;
   logic accept, last_beat;
   assign len_clamp = cfg_len > DEPTH ? DEPTH : cfg_len;
   assign s.ready = state == LOAD && !stall;
   assign accept = s.valid && s.ready;
   assign last_beat = cnt == len - 1'b1;
   // base and cnt are both below DEPTH, so one conditional subtract wraps the address
   assign sum = {1'b0, base} + cnt;
   assign wr_addr = sum >= DEPTH ? ADDR_WIDTH'(sum - DEPTH) : sum[ADDR_WIDTH-1:0];
   assign in_data_valid = state == HOLD;
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  state_n = start ? (len_clamp == '0 ? HOLD : LOAD) : IDLE;
         LOAD:  state_n = accept && last_beat ? FLUSH : LOAD;
         FLUSH: state_n = HOLD;
         HOLD:  state_n = out_data_valid ? IDLE : HOLD;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state             <= IDLE;
         cnt               <= '0;
         len               <= '0;
         base              <= '0;
         BRAM_PORTA_0_we   <= 1'b0;
         BRAM_PORTA_0_addr <= '0;
         BRAM_PORTA_0_din  <= '0;
         err_len           <= 1'b0;
      end else begin
         state           <= state_n;
         BRAM_PORTA_0_we <= accept;
         if (state == IDLE && start) begin
            base    <= cfg_base_addr;
            len     <= len_clamp;
            cnt     <= '0;
            err_len <= 1'b0;
         end
         if (accept) begin
            BRAM_PORTA_0_addr <= wr_addr;
            BRAM_PORTA_0_din  <= s.data;
            cnt               <= cnt + 1'b1;
            if (s.last != last_beat) err_len <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bram_row_loader.sv
// tb_bram_row_loader: scoreboard bench; expected BRAM writes are queued on each accepted beat.
module tb_bram_row_loader;
   import simd_pkg::*;
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] a;
      row_t                  d;
   } wr_t;
   logic clk = 1'b0;
   logic rstn, start, stall, out_data_valid;
   logic [ADDR_WIDTH-1:0] cfg_base_addr, addr;
   logic [ADDR_WIDTH:0] cfg_len;
   row_t din;
   logic we, in_data_valid, busy, err_len;
   wr_t sb[$];
   int n_checks = 0;
   int n_fail = 0;
   bram_row_loader_if sif();
   bram_row_loader dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_base_addr(cfg_base_addr),
      .cfg_len(cfg_len), .stall(stall), .s(sif), .BRAM_PORTA_0_addr(addr),
      .BRAM_PORTA_0_din(din), .BRAM_PORTA_0_we(we), .in_data_valid(in_data_valid),
      .out_data_valid(out_data_valid), .busy(busy), .err_len(err_len)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic row_t row_val(input int f, input int i);
      row_t r;
      for (int j = 0; j < PE_COUNT; j++) r[j] = 32'(f * 256 + (i + 1) * 16 + j);
      return r;
   endfunction
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (sb.size() == 0) check("unexp_write", 128'(we), 128'(0));
         else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 128'(addr), 128'(e.a));
            check("wr_din", 128'(din), 128'(e.d));
         end
      end
   end
   task automatic go(input int b, input int l);
      cfg_base_addr = ADDR_WIDTH'(b);
      cfg_len = (ADDR_WIDTH+1)'(l);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("go_busy", 128'(busy), 128'(1));
   endtask
   task automatic stream(input int f, input int b, input int n, input int last_pos,
                         input int stall_after, input int stall_len);
      int i = 0;
      int guard = 0;
      int stall_left = stall_len;
      while (i < n && guard < 200) begin
         guard++;
         sif.valid = 1'b1;
         sif.data = row_val(f, i);
         sif.last = i == last_pos;
         stall = i == stall_after && stall_left > 0;
         @(negedge clk);
         if (stall) begin
            check("stall_ready", 128'(sif.ready), 128'(0));
            stall_left--;
         end else if (sif.ready) begin
            sb.push_back('{a: ADDR_WIDTH'((b + i) % BRAM_DEPTH), d: row_val(f, i)});
            i++;
         end
         @(posedge clk); #1;
      end
      if (i < n) check("stream_timeout", 128'(i), 128'(n));
      sif.valid = 1'b0;
      sif.last = 1'b0;
      stall = 1'b0;
   endtask
   task automatic post_frame(input logic exp_err);
      check("flush_idv", 128'(in_data_valid), 128'(0));
      check("flush_ready", 128'(sif.ready), 128'(0));
      @(posedge clk); #1;
      check("hold_idv", 128'(in_data_valid), 128'(1));
      check("hold_err", 128'(err_len), 128'(exp_err));
      check("sb_drained", 128'(sb.size()), 128'(0));
   endtask
   task automatic end_frame();
      out_data_valid = 1'b1;
      @(posedge clk); #1;
      out_data_valid = 1'b0;
      check("done_idv", 128'(in_data_valid), 128'(0));
      check("done_busy", 128'(busy), 128'(0));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rstn = 1'b0; start = 1'b0; stall = 1'b0; out_data_valid = 1'b0;
      cfg_base_addr = '0; cfg_len = '0;
      sif.valid = 1'b0; sif.last = 1'b0; sif.data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", 128'(we), 128'(0));
      check("rst_addr", 128'(addr), 128'(0));
      check("rst_din", 128'(din), 128'(0));
      check("rst_idv", 128'(in_data_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_ready", 128'(sif.ready), 128'(0));
      rstn = 1'b1;
      @(posedge clk); #1;
      go(0, 4); stream(1, 0, 4, 3, -1, 0); post_frame(1'b0); end_frame();
      go(2046, 4); stream(2, 2046, 4, 3, -1, 0); post_frame(1'b0); end_frame();
      go(100, 8); stream(3, 100, 8, 7, 3, 5); post_frame(1'b0); end_frame();
      go(10, 4); stream(4, 10, 4, 1, -1, 0); post_frame(1'b1); end_frame();
      check("err_sticky", 128'(err_len), 128'(1));
      go(20, 4);
      check("err_clear", 128'(err_len), 128'(0));
      stream(5, 20, 4, -1, -1, 0); post_frame(1'b1); end_frame();
      go(30, 2); stream(6, 30, 2, 1, -1, 0); post_frame(1'b0);
      cfg_base_addr = 11'd500; cfg_len = 12'd1; start = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stall = 1'b0;
      check("hold_start_idv", 128'(in_data_valid), 128'(1));
      check("hold_start_busy", 128'(busy), 128'(1));
      start = 1'b1; out_data_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; out_data_valid = 1'b0;
      check("start_odv_idv", 128'(in_data_valid), 128'(0));
      check("start_odv_busy", 128'(busy), 128'(0));
      @(posedge clk); #1;
      check("start_dropped", 128'(busy), 128'(0));
      go(40, 3); stream(7, 40, 3, 2, -1, 0); post_frame(1'b0); end_frame();
      go(50, 6); stream(8, 50, 2, -1, -1, 0);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_we", 128'(we), 128'(0));
      check("mid_rst_addr", 128'(addr), 128'(0));
      check("mid_rst_din", 128'(din), 128'(0));
      check("mid_rst_idv", 128'(in_data_valid), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_err", 128'(err_len), 128'(0));
      check("mid_rst_ready", 128'(sif.ready), 128'(0));
      rstn = 1'b1;
      @(posedge clk); #1;
      go(60, 3); stream(9, 60, 3, 2, -1, 0); post_frame(1'b0); end_frame();
      cfg_base_addr = 11'd70; cfg_len = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("len0_idv", 128'(in_data_valid), 128'(1));
      @(posedge clk); #1;
      check("len0_hold", 128'(in_data_valid), 128'(1));
      end_frame();
      repeat (2) @(posedge clk);
      #1;
      check("final_sb", 128'(sb.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
